alu_share_arbiter: RTL and testbench

- Shares one ALU datapath instance among NUM_REQ pipeline requesters, for example the branch comparator and the address adder.
- Uses round-robin arbitration with a valid/ready handshake on every requester port.
- Holds one registered result slot, tagged with the requester ID, toward a downstream consumer that can apply backpressure.
- Sits between the EX-stage issue logic and the ALU; the ALU itself is instantiated inside this block.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu.sv | 27 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_share_arbiter.sv | 118 +++++++++++
 tb/tb_alu_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and opcodes for the shared-ALU arbiter slice.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_EQ  = 4'b1000;
    localparam alu_op_t ALU_NE  = 4'b1001;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath: AND, ADD, EQ, NE; any other opcode yields 0.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]    result
);

    // Decode the opcode; unknown codes fall through to a zero result.
    always_comb begin
        result = '0;
        if (op == OPCODE_LENGTH'(ALU_AND))
            result = srca & srcb;
        else if (op == OPCODE_LENGTH'(ALU_ADD))
            result = srca + srcb;
        else if (op == OPCODE_LENGTH'(ALU_EQ))
            result = DATA_WIDTH'(srca == srcb);
        else if (op == OPCODE_LENGTH'(ALU_NE))
            result = DATA_WIDTH'(srca != srcb);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int k;

    // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins.
    always_comb begin
        k     = 0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(ptr) + off;
            if (k >= NUM_REQ)
                k = k - NUM_REQ;
            if (!any && req[ID_W'(k)]) begin
                any = 1'b1;
                idx = ID_W'(k);
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters through a round-robin valid/ready arbiter,
// with a single registered, ID-tagged result slot toward a backpressuring consumer.
// Optional: define ALU_ARB_PERF_EN to add perf_ops / perf_stall counter ports.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int OPCODE_LENGTH = 4,
    parameter  int NUM_REQ       = 2,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_srca,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_srcb,
    input  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0]  req_op,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [ID_W-1:0]                        rsp_id,
    output logic [DATA_WIDTH-1:0]                  rsp_result
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]                            perf_ops,
    output logic [31:0]                            perf_stall
`endif
);

    slot_state_t            state_q, state_d;
    logic [ID_W-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;
    logic                   can_accept;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  alu_result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca   (req_srca[gnt_idx]),
        .srcb   (req_srcb[gnt_idx]),
        .op     (req_op[gnt_idx]),
        .result (alu_result)
    );

    // The slot can take a new result when empty or when it drains this cycle;
    // grants are forced low during reset so nothing looks accepted.
    always_comb begin
        can_accept = (state_q == EMPTY) || rsp_ready;
        accept     = gnt_any && can_accept && !reset;
        req_ready  = accept ? grant : '0;
    end

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Slot next state: fill on accept, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign rsp_valid = (state_q == FULL);

    // Capture the winner's result and tag; advance the pointer past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result <= '0;
            rsp_id     <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            rsp_result <= alu_result;
            rsp_id     <= gnt_idx;
            rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Free-running accept and stall counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept)
                perf_ops <= perf_ops + 32'd1;
            if (rsp_valid && !rsp_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // Counters are compiled out; core behaviour is unchanged.
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (NUM_REQ=2, 32-bit data).
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OL = 4;
    localparam int NR = 2;
    localparam int IW = 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][DW-1:0]  req_srca;
    logic [NR-1:0][DW-1:0]  req_srcb;
    logic [NR-1:0][OL-1:0]  req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [DW-1:0]          rsp_result;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]            perf_ops;
    logic [31:0]            perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (OL),
        .NUM_REQ       (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Requester rule: a pending request and its operands hold until granted.
    for (genvar i = 0; i < NR; i++) begin : g_hold
        assert property (@(posedge clk) disable iff (reset)
            (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_srca[i]) && $stable(req_srcb[i]) && $stable(req_op[i])))
        else begin
            n_fail++;
            $display("FAIL req_hold[%0d]: request dropped or changed before grant", i);
        end
    end

    // Grants are one-hot or empty.
    assert property (@(posedge clk) $onehot0(req_ready))
    else begin
        n_fail++;
        $display("FAIL grant_onehot: req_ready=%b", req_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        req_op[i]   = op;
        req_srca[i] = a;
        req_srcb[i] = b;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, ALU_ADD, 32'h1, 32'h1);
        set_req(1, ALU_ADD, 32'h2, 32'h2);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %h want 0", rsp_id); end
        n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", rsp_result); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        repeat (2) tick();
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready_held: got %b want 00", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // rr_ptr=0, only req1 valid, then req0, then req1.
    task automatic test_only_req1();
        req_valid = 2'b10;
        set_req(1, ALU_ADD, 32'h4, 32'h5);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL only1_grant1: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'h1, 32'h2);
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'h9}) begin n_fail++; $display("FAIL only1_rsp1: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'h9}); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL only1_grant0: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        set_req(1, ALU_AND, 32'hFF, 32'h0F);
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h3}) begin n_fail++; $display("FAIL only1_rsp0: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'h3}); end
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL only1_grant1b: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'hF}) begin n_fail++; $display("FAIL only1_rsp1b: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'hF}); end
        tick();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL only1_drain: got %b want 0", rsp_valid); end
        tick();
    endtask

    // Both requesters valid, rr_ptr=0: grants alternate with no bubbles.
    task automatic test_back_to_back();
        logic [1:0]  exp_g [5];
        logic [31:0] exp_r [2];
        logic        prev;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        exp_r = '{32'hB, 32'h30};
        prev  = 1'b0;
        set_req(0, ALU_ADD, 32'd10, 32'd1);
        set_req(1, ALU_AND, 32'hF0, 32'h3C);
        for (int k = 0; k < 5; k++) begin
            req_valid = (k == 4) ? 2'b01 : 2'b11;
            @(negedge clk);
            n_checks++; if (req_ready !== exp_g[k]) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", k, req_ready, exp_g[k]); end
            if (k > 0) begin
                n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, prev, exp_r[prev]}) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %h want %h", k, {rsp_valid, rsp_id, rsp_result}, {1'b1, prev, exp_r[prev]}); end
            end
            prev = (exp_g[k] == 2'b10);
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'hB}) begin n_fail++; $display("FAIL b2b_last: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'hB}); end
        tick();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
        tick();
    endtask

    // ADD wraps modulo 2^32.
    task automatic test_add_wrap();
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'hFFFF_FFFF, 32'h2);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wrap_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h1}) begin n_fail++; $display("FAIL wrap_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'h1}); end
        tick();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: got %b want 0", rsp_valid); end
        tick();
    endtask

    // EQ from req1, then three stall cycles with req0 waiting, then drain+accept.
    task automatic test_stall();
        req_valid = 2'b10;
        set_req(1, ALU_EQ, 32'd7, 32'd7);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_grant1: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        set_req(0, ALU_ADD, 32'h1, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'h1}) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", k, {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'h1}); end
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 00", k, req_ready); end
            tick();
        end
`ifdef ALU_ARB_PERF_EN
        n_checks++; if (perf_stall !== 32'd3) begin n_fail++; $display("FAIL perf_stall: got %0d want 3", perf_stall); end
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_release: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h2}) begin n_fail++; $display("FAIL stall_refill: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'h2}); end
        tick();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", rsp_valid); end
        tick();
    endtask

    // Undefined opcode gives 0; NE 3,4 gives 1.
    task automatic test_illegal_op();
        req_valid = 2'b01;
        set_req(0, 4'b0110, 32'hA, 32'hB);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL illop_grant: got %b want 01", req_ready); end
        tick();
        set_req(0, ALU_NE, 32'd3, 32'd4);
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL illop_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'h0}); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h1}) begin n_fail++; $display("FAIL ne_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'h1}); end
        tick();
    endtask

    // Asynchronous reset with the slot holding 0x5 and a request pending.
    task automatic test_reset_mid();
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'h2, 32'h3);
        @(negedge clk);
        tick();
        rsp_ready = 1'b0;
        set_req(0, ALU_ADD, 32'h7, 32'h7);
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_result} !== {1'b1, 32'h5}) begin n_fail++; $display("FAIL rmid_full: got %h want %h", {rsp_valid, rsp_result}, {1'b1, 32'h5}); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL rmid_clear: got %h want 0", {rsp_valid, rsp_id, rsp_result}); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rmid_ready: got %b want 00", req_ready); end
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_regrant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'hE}) begin n_fail++; $display("FAIL rmid_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'hE}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_only_req1();
        test_back_to_back();
        test_add_wrap();
        test_stall();
        test_illegal_op();
        test_reset_mid();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end

endmodule
